// File: rtl/skid_register_if.sv
// skid_register_if: upstream/downstream handshake bundle for skid_register.
interface skid_register_if #(
  parameter int P_WIDTH = 16
);
  logic               I_FLUSH;
  logic               I_VALID;
  logic [P_WIDTH-1:0] I_DATA;
  logic               O_READY;
  logic               O_VALID;
  logic [P_WIDTH-1:0] O_DATA;
  logic               I_READY;
  logic [1:0]         O_COUNT;
  modport slave (
    input  I_FLUSH, I_VALID, I_DATA, I_READY,
    output O_READY, O_VALID, O_DATA, O_COUNT
  );
  modport master (
    output I_FLUSH, I_VALID, I_DATA, I_READY,
    input  O_READY, O_VALID, O_DATA, O_COUNT
  );
endinterface

// File: rtl/skid_register.sv
// skid_register: two-entry valid/ready pipeline register with fully registered ready and valid.
module skid_register #(
  parameter int P_WIDTH = 16
) (
  input logic            I_CLK,
  input logic            I_RESET,
  skid_register_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] main_q, main_d;
  logic [P_WIDTH-1:0] skid_q, skid_d;
  logic               in_fire, out_fire;
  // State encoding doubles as the occupancy count, so every output is a plain decode.
  assign bus.O_VALID = state_q != EMPTY;
  assign bus.O_READY = state_q != FULL;
  assign bus.O_COUNT = state_q;
  assign bus.O_DATA  = main_q;
  assign in_fire  = bus.I_VALID & bus.O_READY;
  assign out_fire = bus.O_VALID & bus.I_READY;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.I_FLUSH) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          state_d = in_fire ? BUSY : EMPTY;
          main_d  = in_fire ? bus.I_DATA : main_q;
        end
        BUSY: begin
          state_d = in_fire ? (out_fire ? BUSY : FULL) : (out_fire ? EMPTY : BUSY);
          main_d  = (in_fire & out_fire) ? bus.I_DATA : main_q;
          skid_d  = (in_fire & !out_fire) ? bus.I_DATA : skid_q;
        end
        FULL: begin
          state_d = out_fire ? BUSY : FULL;
          main_d  = out_fire ? skid_q : main_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_skid_register.sv
// tb_skid_register: directed vector table plus an alternating-stall scoreboard sequence.
module tb_skid_register;
  logic I_CLK = 1'b0;
  logic I_RESET;
  int   checks = 0;
  int   errors = 0;
  skid_register_if #(.P_WIDTH(16)) bus ();
  skid_register #(.P_WIDTH(16)) dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .bus     (bus)
  );
  always #5 I_CLK = ~I_CLK;
  typedef struct {
    logic        r;
    logic        f;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic        er;
    logic [15:0] ed;
    logic [1:0]  ec;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic add(input logic r, f, v, input logic [15:0] d, input logic rdy,
                     input logic ev, er, input logic [15:0] ed, input logic [1:0] ec);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.er = er; t.ed = ed; t.ec = ec;
    tv.push_back(t);
  endtask
  initial begin
    int sent, recv, c;
    logic [15:0] held;
    logic stalled, inf, outf;
    I_RESET = 1'b1;
    bus.I_FLUSH = 1'b0;
    bus.I_VALID = 1'b0;
    bus.I_DATA  = '0;
    bus.I_READY = 1'b0;
    // reset / idle
    add(1, 0, 1, 16'hFFFF, 0, 0, 1, 16'h0000, 0);
    add(1, 0, 1, 16'hFFFF, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'hFFFF, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0);
    // streaming 1..10 then drain
    for (int i = 1; i <= 10; i++) add(0, 0, 1, 16'(i), 1, 1, 1, 16'(i), 1);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'd10, 0);
    // backpressure into skid, ignored offer while full, drain
    add(0, 0, 1, 16'hA5A5, 0, 1, 1, 16'hA5A5, 1);
    add(0, 0, 1, 16'h5A5A, 0, 1, 0, 16'hA5A5, 2);
    add(0, 0, 1, 16'hDEAD, 0, 1, 0, 16'hA5A5, 2);
    add(0, 0, 1, 16'hDEAD, 1, 1, 1, 16'h5A5A, 1);
    add(0, 0, 0, 16'hDEAD, 1, 0, 1, 16'h5A5A, 0);
    // flush from FULL with a simultaneous offer
    add(0, 0, 1, 16'h1111, 0, 1, 1, 16'h1111, 1);
    add(0, 0, 1, 16'h2222, 0, 1, 0, 16'h1111, 2);
    add(0, 1, 1, 16'h3333, 0, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h3333, 1, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0);
    // reset beats flush and a pending transfer
    add(0, 0, 1, 16'h4444, 0, 1, 1, 16'h4444, 1);
    add(1, 1, 1, 16'h5555, 1, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h5555, 0, 0, 1, 16'h0000, 0);
    foreach (tv[i]) begin
      @(negedge I_CLK);
      I_RESET     = tv[i].r;
      bus.I_FLUSH = tv[i].f;
      bus.I_VALID = tv[i].v;
      bus.I_DATA  = tv[i].d;
      bus.I_READY = tv[i].rdy;
      @(posedge I_CLK);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.O_VALID), 32'(tv[i].ev));
      chk($sformatf("v%0d_ready", i), 32'(bus.O_READY), 32'(tv[i].er));
      chk($sformatf("v%0d_data", i),  32'(bus.O_DATA),  32'(tv[i].ed));
      chk($sformatf("v%0d_count", i), 32'(bus.O_COUNT), 32'(tv[i].ec));
    end
    // alternating stall: 20 words, I_READY toggles every cycle
    I_RESET = 1'b0;
    bus.I_FLUSH = 1'b0;
    sent = 0;
    recv = 0;
    stalled = 1'b0;
    held = '0;
    c = 0;
    while (c < 200 && recv < 20) begin
      @(negedge I_CLK);
      if (stalled) begin
        chk("alt_stall_valid", 32'(bus.O_VALID), 32'd1);
        chk("alt_stall_data", 32'(bus.O_DATA), 32'(held));
      end
      chk("alt_count", 32'(bus.O_COUNT), 32'(sent - recv));
      bus.I_VALID = sent < 20;
      bus.I_DATA  = 16'(16'h0100 + sent);
      bus.I_READY = c[0];
      inf  = bus.I_VALID & bus.O_READY;
      outf = bus.O_VALID & bus.I_READY;
      if (outf) begin
        chk("alt_data", 32'(bus.O_DATA), 32'(16'h0100 + recv));
        recv++;
      end
      stalled = bus.O_VALID & !bus.I_READY;
      held = bus.O_DATA;
      if (inf) sent++;
      c++;
    end
    chk("alt_delivered", 32'(recv), 32'd20);
    @(negedge I_CLK);
    bus.I_VALID = 1'b0;
    bus.I_READY = 1'b1;
    @(posedge I_CLK);
    #1;
    chk("alt_empty_count", 32'(bus.O_COUNT), 32'd0);
    chk("alt_empty_valid", 32'(bus.O_VALID), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
